dbus_write_buffer: RTL
======================

// Module: dbus_write_buffer
// PURPOSE
//  Posted-write buffer between the CPU data bus (Dw* signals) and the data memory/MMIO bus.
//  - CPU stores are queued in a small FIFO and retire to memory in the background.
//  - CPU loads are strictly ordered behind all queued stores.
//  - oStall holds the multicycle/pipeline core while a load is pending or the FIFO is full.
// PARAMETERS
//  DEPTH  4   FIFO entries, power of two, >=2
//  AW     32  address width
//  DW     32  data width (byte enables = DW/8)
// PORTS
//  iCLK          in   1      clock
//  iRST          in   1      synchronous reset, active-high
//  iReadEnable   in   1      CPU load request (DwReadEnable)
//  iWriteEnable  in   1      CPU store request (DwWriteEnable)
//  iByteEnable   in   DW/8   CPU byte enables (DwByteEnable)
//  iAddress      in   AW     CPU address (DwAddress)
//  iWriteData    in   DW     CPU store data (DwWriteData)
//  oReadData     out  DW     load data to CPU (DwReadData), registered
//  oStall        out  1      CPU must hold its request and not advance
//  oMReq         out  1      memory request, held until iMAck
//  oMWe          out  1      1 = write, 0 = read
//  oMAddr        out  AW     memory address
//  oMBE          out  DW/8   memory byte enables
//  oMWData       out  DW     memory write data
//  iMAck         in   1      memory completes current request this cycle
//  iMRData       in   DW     memory read data, valid when iMAck && !oMWe
//  oEmpty        out  1      FIFO empty and no memory transaction open
// BEHAVIOUR
//  Reset (iRST=1 at an edge):
//  - count=0, rd/wr pointers=0, state=IDLE.
//  - Outputs: oMReq=0, oMWe=0, oMAddr=0, oMBE=0, oMWData=0, oReadData=0, oEmpty=1.
//  - oStall is combinational: 0 with no request; 1 if iReadEnable is held during/after reset.
//  - Reset mid-transaction drops the open request and flushes the FIFO; a late iMAck in IDLE is ignored.
//  Stores (FIFO side, always active regardless of FSM state):
//  - Push {addr, be, data} at the edge when iWriteEnable && count<DEPTH (registered count).
//  - A push is accepted the same cycle it is presented.
//  - Full: oStall=1; the store is held and accepted at the first edge with count<DEPTH.
//  - A pop and a push in the same cycle are legal; count is unchanged.
//  Loads:
//  - iReadEnable && iWriteEnable is illegal; the read wins and the write is ignored (flag with an assertion).
//  - oStall = (iReadEnable && state!=RDONE) || (iWriteEnable && count==DEPTH).
//  FSM (registered outputs):
//  - IDLE: if count>0 -> WRITE; else if iReadEnable -> READ.
//    - Drain has priority, so a load waits for every older store.
//  - WRITE:
//    - oMReq=1, oMWe=1; oMAddr/oMBE/oMWData = FIFO head.
//    - On iMAck: pop the head. If entries remain, present the next head the following cycle (stay WRITE); else -> IDLE.
//  - READ:
//    - oMReq=1, oMWe=0, oMAddr=iAddress latched on entry, oMBE=iByteEnable latched.
//    - On iMAck: oReadData<=iMRData, -> RDONE.
//  - RDONE: oMReq=0, oStall=0 this cycle (CPU consumes oReadData), -> IDLE.
//    - oReadData holds its value until the next load completes.
//  - oMReq deasserts in the cycle after iMAck unless another transaction follows back-to-back.
//  Timing:
//  - Minimum load latency with an empty FIFO and zero-wait memory: request cycle k, iMAck at k+1, RDONE at k+2.
//    oStall is high in cycles k and k+1 (2 stall cycles).
//  - Store throughput is 1 per cycle into the FIFO and 1 per iMAck out.
//  Other rules:
//  - Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits and never exceeds DEPTH or underflows.
//  - oEmpty = (count==0) && state==IDLE.
// TESTING
//  1. Reset, then hold iReadEnable@0x100 with the FIFO empty; mem acks 1 cycle later with 0xDEADBEEF
//     -> oStall high 2 cycles, then oReadData=0xDEADBEEF, oStall=0, one oMReq read.
//  2. Four back-to-back stores (0x10..0x1C, data 1..4, be=4'hF) with iMAck held low
//     -> no stall; count=4; a 5th store stalls until the first ack; memory sees 1,2,3,4,5 in order.
//  3. Store 0xAA to 0x20, then a load from 0x20 next cycle
//     -> memory write (0x20, 0xAA) completes before oMReq read to 0x20; load stalls throughout.
//  4. Byte store be=4'b0100 to 0x30 -> oMBE=4'b0100, oMWData passed unchanged, oMWe=1.
//  5. Assert iRST while in WRITE with 3 entries queued, ack arriving the same cycle
//     -> next cycle oMReq=0, oEmpty=1, no further memory traffic.
//  6. Wrap: 10 stores with random 0-3 cycle ack delays -> all 10 retire in order; count never >DEPTH.

Source files
------------

// File: rtl/dbus_write_buffer_if.sv
// Bundle of CPU data-bus and memory-bus signals seen by the posted-write buffer.
// The slave modport is the buffer's view; the master modport is the CPU/memory environment's view.
interface dbus_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              iReadEnable;
    logic              iWriteEnable;
    logic [DW/8-1:0]   iByteEnable;
    logic [AW-1:0]     iAddress;
    logic [DW-1:0]     iWriteData;
    logic [DW-1:0]     oReadData;
    logic              oStall;
    logic              oMReq;
    logic              oMWe;
    logic [AW-1:0]     oMAddr;
    logic [DW/8-1:0]   oMBE;
    logic [DW-1:0]     oMWData;
    logic              iMAck;
    logic [DW-1:0]     iMRData;
    logic              oEmpty;

    modport slave (
        input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData, iMAck, iMRData,
        output oReadData, oStall, oMReq, oMWe, oMAddr, oMBE, oMWData, oEmpty
    );

    modport master (
        output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData, iMAck, iMRData,
        input  oReadData, oStall, oMReq, oMWe, oMAddr, oMBE, oMWData, oEmpty
    );
endinterface

// File: rtl/dbus_write_buffer.sv
// Posted-write buffer: CPU stores queue in a small FIFO and drain in the background;
// loads wait behind every queued store before issuing to memory.
module dbus_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic             iCLK,
    input logic             iRST,
    dbus_write_buffer_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULLCNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONECNT  = (PW + 1)'(1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } entryT;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} stateT;

    stateT         state;
    entryT         fifo [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr, rdPtrNext;
    logic [PW:0]   count;
    logic          push, pop;
    entryT         head, nextHead;

    // A simultaneous load wins; the store is dropped.
    assign push      = bus.iWriteEnable && !bus.iReadEnable && (count < FULLCNT);
    assign pop       = (state == WRITE) && bus.iMAck;
    assign rdPtrNext = rdPtr + 1'b1;
    assign head      = fifo[rdPtr];
    assign nextHead  = fifo[rdPtrNext];

    assign bus.oStall = (bus.iReadEnable && state != RDONE) ||
                        (bus.iWriteEnable && count == FULLCNT);
    assign bus.oEmpty = (count == '0) && (state == IDLE);

    always_ff @(posedge iCLK) begin
        if (push) fifo[wrPtr] <= '{addr: bus.iAddress, be: bus.iByteEnable, data: bus.iWriteData};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state         <= IDLE;
            rdPtr         <= '0;
            wrPtr         <= '0;
            count         <= '0;
            bus.oMReq     <= 1'b0;
            bus.oMWe      <= 1'b0;
            bus.oMAddr    <= '0;
            bus.oMBE      <= '0;
            bus.oMWData   <= '0;
            bus.oReadData <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtrNext;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    // Draining first keeps loads ordered behind older stores.
                    if (count != '0) begin
                        state       <= WRITE;
                        bus.oMReq   <= 1'b1;
                        bus.oMWe    <= 1'b1;
                        bus.oMAddr  <= head.addr;
                        bus.oMBE    <= head.be;
                        bus.oMWData <= head.data;
                    end else if (bus.iReadEnable) begin
                        state      <= READ;
                        bus.oMReq  <= 1'b1;
                        bus.oMWe   <= 1'b0;
                        bus.oMAddr <= bus.iAddress;
                        bus.oMBE   <= bus.iByteEnable;
                    end
                end
                WRITE: begin
                    if (bus.iMAck) begin
                        if (count > ONECNT) begin
                            bus.oMAddr  <= nextHead.addr;
                            bus.oMBE    <= nextHead.be;
                            bus.oMWData <= nextHead.data;
                        end else begin
                            state     <= IDLE;
                            bus.oMReq <= 1'b0;
                            bus.oMWe  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (bus.iMAck) begin
                        state         <= RDONE;
                        bus.oMReq     <= 1'b0;
                        bus.oReadData <= bus.iMRData;
                    end
                end
                RDONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    rdWrExclusive: assert property (@(posedge iCLK) disable iff (iRST)
        !(bus.iReadEnable && bus.iWriteEnable));

endmodule
